// File: rtl/mux_scan_nto1.sv
// Registered N:1 multiplexer with manual select and HOLD-cycle scan mode.
// Latency: 1 cycle from sample edge to y/cur_sel/y_valid/wrap.
// Backpressure: none; en low freezes all state and drops y_valid for that cycle.
// Optional feature macro: MUX_PARITY_EN adds y_par (even parity of y).
module mux_scan_nto1 #(
    parameter int N     = 8,
    parameter int W     = 1,
    // Derived from N; leave at its default.
    parameter int SEL_W = $clog2(N),
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   a,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     y,
    output logic             y_valid,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
`ifdef MUX_PARITY_EN
    ,
    output logic             y_par
`endif
);

    // Dwell counter must hold 0..HOLD-1; keep at least one bit for HOLD = 1.
    localparam int               DW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DW-1:0]    DLAST    = DW'(HOLD - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

    // Registered mode: tells the first scan cycle (entry) apart from a running scan.
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [W-1:0]     y_q, y_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;

    logic             sel_ok;
    logic             scan_entry;
    logic [SEL_W-1:0] ptr_eff;
    logic [DW-1:0]    dcnt_eff;
    logic [SEL_W-1:0] src_sel;
    logic [W-1:0]     ch_dat;

    // sel may exceed N-1 when N is not a power of two.
    assign sel_ok = ({1'b0, sel} < N_EXT);

    // Resolve the channel sampled this cycle; scan entry restarts from sel (or 0 if out of range).
    always_comb begin
        scan_entry = mode && (state_q == ST_MANUAL);
        ptr_eff    = ptr_q;
        dcnt_eff   = dcnt_q;
        if (scan_entry) begin
            ptr_eff  = sel_ok ? sel : '0;
            dcnt_eff = '0;
        end
        src_sel = mode ? ptr_eff : sel;
    end

    // Channel mux; select values with no matching channel yield zero.
    always_comb begin
        ch_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (src_sel == SEL_W'(k)) begin
                ch_dat = a[k*W +: W];
            end
        end
    end

    // Next-state: sample on en, advance scan pointer after HOLD dwell cycles.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        y_d     = y_q;
        cur_d   = cur_q;
        vld_d   = 1'b0;
        wrap_d  = 1'b0;
        if (en) begin
            state_d = mode ? ST_SCAN : ST_MANUAL;
            y_d     = ch_dat;
            cur_d   = src_sel;
            vld_d   = 1'b1;
            if (mode) begin
                // ptr only reaches 0 with dcnt 0 outside entry by stepping from N-1,
                // so this flags the first presentation of channel 0 after a wrap.
                wrap_d = !scan_entry && (ptr_q == '0) && (dcnt_q == '0);
                if (dcnt_eff == DLAST) begin
                    dcnt_d = '0;
                    ptr_d  = (ptr_eff == PTR_LAST) ? '0 : ptr_eff + SEL_W'(1);
                end else begin
                    dcnt_d = dcnt_eff + DW'(1);
                    ptr_d  = ptr_eff;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            ptr_q   <= '0;
            dcnt_q  <= '0;
            y_q     <= '0;
            cur_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            y_q     <= y_d;
            cur_q   <= cur_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y       = y_q;
    assign y_valid = vld_q;
    assign cur_sel = cur_q;
    assign wrap    = wrap_q;

`ifdef MUX_PARITY_EN
    logic y_par_q;

    // Parity captured on the same edge as y so the pair always agrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par_q <= 1'b0;
        end else if (en) begin
            y_par_q <= ^ch_dat;
        end
    end

    assign y_par = y_par_q;
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
module tb_mux_scan_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a8;
    logic [5:0]  a6;
    logic [2:0]  sel8, sel6;
    logic        mode8, mode6, en8, en6;
    logic [3:0]  y8;
    logic [0:0]  y6;
    logic        v8, v6, w8, w6;
    logic [2:0]  cs8, cs6;
`ifdef MUX_PARITY_EN
    logic        p8, p6;
`endif

    mux_scan_nto1 #(.N(8), .W(4), .HOLD(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .sel(sel8), .mode(mode8), .en(en8),
        .y(y8), .y_valid(v8), .cur_sel(cs8), .wrap(w8)
`ifdef MUX_PARITY_EN
        , .y_par(p8)
`endif
    );

    mux_scan_nto1 #(.N(6), .W(1), .HOLD(1)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .sel(sel6), .mode(mode6), .en(en6),
        .y(y6), .y_valid(v6), .cur_sel(cs6), .wrap(w6)
`ifdef MUX_PARITY_EN
        , .y_par(p6)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: scan position is derived from the number of enabled
    // scan cycles since entry, channel = (start + k/HOLD) mod N.
    bit          sc[2];
    int          st[2];
    int          kk[2];
    logic [31:0] ey[2];
    bit          ev[2];
    int          ec[2];
    bit          ew[2];
    bit          ep[2];

    task automatic model_reset(input int id);
        sc[id] = 0; st[id] = 0; kk[id] = 0;
        ey[id] = 0; ev[id] = 0; ec[id] = 0; ew[id] = 0; ep[id] = 0;
    endtask

    task automatic model_step(input int id, input int n, input int w, input int hold,
                              input logic [31:0] av, input int s, input bit md, input bit e);
        int ch;
        if (!e) begin
            ev[id] = 0;
            ew[id] = 0;
            return;
        end
        ev[id] = 1;
        ew[id] = 0;
        if (!md) begin
            sc[id] = 0;
            ch = s;
        end else begin
            if (!sc[id]) begin
                sc[id] = 1;
                st[id] = (s < n) ? s : 0;
                kk[id] = 0;
            end
            ch = (st[id] + kk[id] / hold) % n;
            ew[id] = (kk[id] > 0) && (kk[id] % hold == 0) && (ch == 0);
            kk[id]++;
        end
        ec[id] = ch;
        ey[id] = (ch < n) ? ((av >> (ch * w)) & ((32'd1 << w) - 32'd1)) : 32'd0;
        ep[id] = ^ey[id];
    endtask

    task automatic check_all();
        chk("y8", {28'd0, y8}, ey[0]);
        chk("vld8", {31'd0, v8}, {31'd0, ev[0]});
        chk("cur8", {29'd0, cs8}, ec[0]);
        chk("wrap8", {31'd0, w8}, {31'd0, ew[0]});
        chk("y6", {31'd0, y6}, ey[1]);
        chk("vld6", {31'd0, v6}, {31'd0, ev[1]});
        chk("cur6", {29'd0, cs6}, ec[1]);
        chk("wrap6", {31'd0, w6}, {31'd0, ew[1]});
`ifdef MUX_PARITY_EN
        chk("par8", {31'd0, p8}, {31'd0, ep[0]});
        chk("par6", {31'd0, p6}, {31'd0, ep[1]});
`endif
    endtask

    // One clock: update the model with the inputs seen at the edge, then check 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 8, 4, 2, a8, int'(sel8), mode8, en8);
            model_step(1, 6, 1, 1, {26'd0, a6}, int'(sel6), mode6, en6);
        end
        #1;
        check_all();
    endtask

    int exp_cur3[8]  = '{6, 6, 7, 7, 0, 0, 1, 1};
    bit exp_wrap3[8] = '{0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst_n = 1'b0;
        a8 = '0; a6 = '0; sel8 = '0; sel6 = '0;
        mode8 = 1'b0; mode6 = 1'b0; en8 = 1'b0; en6 = 1'b0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        chk("rst_y8", {28'd0, y8}, 32'd0);
        chk("rst_vld8", {31'd0, v8}, 32'd0);
        rst_n = 1'b1;

        // Manual select and hold
        a8 = 32'h7654_3210; mode8 = 1'b0; en8 = 1'b1; sel8 = 3'd3;
        tick();
        chk("man_y", {28'd0, y8}, 32'd3);
        chk("man_cur", {29'd0, cs8}, 32'd3);
        chk("man_vld", {31'd0, v8}, 32'd1);
        en8 = 1'b0;
        tick();
        chk("man_hold_y", {28'd0, y8}, 32'd3);
        chk("man_hold_vld", {31'd0, v8}, 32'd0);
        en8 = 1'b1;
        tick();

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", {28'd0, y8}, 32'd0);
        chk("arst_vld", {31'd0, v8}, 32'd0);
        chk("arst_cur", {29'd0, cs8}, 32'd0);
        chk("arst_wrap", {31'd0, w8}, 32'd0);
        model_reset(0);
        model_reset(1);
        tick();
        rst_n = 1'b1;

        // Scan sweep from channel 6 with wrap
        mode8 = 1'b1; sel8 = 3'd6; en8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sweep_cur", {29'd0, cs8}, exp_cur3[i]);
            chk("sweep_wrap", {31'd0, w8}, {31'd0, exp_wrap3[i]});
        end

        // Freeze mid-dwell on channel 2
        tick();
        chk("frz_pre", {29'd0, cs8}, 32'd2);
        en8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_cur", {29'd0, cs8}, 32'd2);
            chk("frz_vld", {31'd0, v8}, 32'd0);
        end
        en8 = 1'b1;
        tick();
        chk("frz_resume", {29'd0, cs8}, 32'd2);
        tick();
        chk("frz_next", {29'd0, cs8}, 32'd3);
        for (int i = 0; i < 4; i++) tick();
        chk("at5", {29'd0, cs8}, 32'd5);

        // Mode switch scan -> manual -> scan
        mode8 = 1'b0; sel8 = 3'd1;
        tick();
        chk("sw_man_y", {28'd0, y8}, 32'd1);
        mode8 = 1'b1; sel8 = 3'd4;
        tick();
        chk("sw_scan_cur", {29'd0, cs8}, 32'd4);
        tick();
        tick();
        chk("sw_scan_adv", {29'd0, cs8}, 32'd5);

        // N=6, HOLD=1: out-of-range select
        a6 = 6'b001000; mode6 = 1'b0; sel6 = 3'd7; en6 = 1'b1;
        tick();
        chk("oor_y", {31'd0, y6}, 32'd0);
        chk("oor_vld", {31'd0, v6}, 32'd1);
        mode6 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("oor_scan_cur", {29'd0, cs6}, (i == 6) ? 32'd0 : i);
            chk("oor_scan_wrap", {31'd0, w6}, (i == 6) ? 32'd1 : 32'd0);
            if (i == 3) begin
                chk("ch3_y", {31'd0, y6}, 32'd1);
`ifdef MUX_PARITY_EN
                chk("ch3_par", {31'd0, p6}, 32'd1);
`endif
            end
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            a8 = $urandom;
            a6 = 6'($urandom);
            sel8 = 3'($urandom);
            sel6 = 3'($urandom);
            if ($urandom_range(7) == 0) mode8 = ~mode8;
            if ($urandom_range(7) == 0) mode6 = ~mode6;
            en8 = ($urandom_range(3) != 0);
            en6 = ($urandom_range(3) != 0);
            rst_n = ($urandom_range(99) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
